// File: rtl/turn_signal_decoder.sv
// rtl/turn_signal_decoder.sv - receive-side monitor for the 6-lamp tail-light bus
// Decodes left/right lamp sequences, pulses on completion, flags illegal or stalled patterns.

module turn_signal_decoder #(
  parameter int MAX_HOLD = 4,
  parameter int ERR_CW   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic [5:0]        leds,
  output logic [1:0]        mode,
  output logic [1:0]        phase,
  output logic              left_done,
  output logic              right_done,
  output logic              seq_err,
  output logic [ERR_CW-1:0] err_cnt
);

  localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

  localparam logic [5:0] PAT_IDLE = 6'h00;
  localparam logic [5:0] PAT_L1   = 6'h08;
  localparam logic [5:0] PAT_L2   = 6'h18;
  localparam logic [5:0] PAT_L3   = 6'h38;
  localparam logic [5:0] PAT_R1   = 6'h04;
  localparam logic [5:0] PAT_R2   = 6'h06;
  localparam logic [5:0] PAT_R3   = 6'h07;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L1   = 3'd1,
    L2   = 3'd2,
    L3   = 3'd3,
    R1   = 3'd4,
    R2   = 3'd5,
    R3   = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [1:0]          mode_q, mode_d;
  logic [1:0]          phase_q, phase_d;
  logic                left_done_q, left_done_d;
  logic                right_done_q, right_done_d;
  logic                seq_err_q, seq_err_d;
  logic [ERR_CW-1:0]   err_cnt_q, err_cnt_d;

  logic [5:0]          cur_pat;
  logic                err;

  function automatic logic [5:0] pattern_of(input state_t s);
    case (s)
      L1:      pattern_of = PAT_L1;
      L2:      pattern_of = PAT_L2;
      L3:      pattern_of = PAT_L3;
      R1:      pattern_of = PAT_R1;
      R2:      pattern_of = PAT_R2;
      R3:      pattern_of = PAT_R3;
      default: pattern_of = PAT_IDLE;
    endcase
  endfunction

  function automatic logic [1:0] mode_of(input state_t s);
    case (s)
      L1, L2, L3: mode_of = 2'b01;
      R1, R2, R3: mode_of = 2'b10;
      default:    mode_of = 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] phase_of(input state_t s);
    case (s)
      L1, R1:  phase_of = 2'd1;
      L2, R2:  phase_of = 2'd2;
      L3, R3:  phase_of = 2'd3;
      default: phase_of = 2'd0;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    left_done_d  = 1'b0;
    right_done_d = 1'b0;
    seq_err_d    = 1'b0;
    err_cnt_d    = err_cnt_q;
    err          = 1'b0;
    cur_pat      = pattern_of(state_q);

    if (clk_en) begin
      if (state_q != IDLE && leds == cur_pat) begin
        // Repeat of the current lamp pattern: legal until the hold budget is spent.
        if (hold_cnt_q == HOLD_W'(MAX_HOLD)) begin
          err = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (leds == PAT_L1) begin
              state_d    = L1;
              hold_cnt_d = '0;
            end else if (leds == PAT_R1) begin
              state_d    = R1;
              hold_cnt_d = '0;
            end else if (leds != PAT_IDLE) begin
              err = 1'b1;
            end
          end
          L1, R1, L2, R2: begin
            if (leds == PAT_IDLE) begin
              state_d    = IDLE;
              hold_cnt_d = '0;
            end else if (state_q == L1 && leds == PAT_L2) begin
              state_d    = L2;
              hold_cnt_d = '0;
            end else if (state_q == L2 && leds == PAT_L3) begin
              state_d    = L3;
              hold_cnt_d = '0;
            end else if (state_q == R1 && leds == PAT_R2) begin
              state_d    = R2;
              hold_cnt_d = '0;
            end else if (state_q == R2 && leds == PAT_R3) begin
              state_d    = R3;
              hold_cnt_d = '0;
            end else begin
              err = 1'b1;
            end
          end
          L3, R3: begin
            if (leds == PAT_IDLE) begin
              state_d      = IDLE;
              hold_cnt_d   = '0;
              left_done_d  = (state_q == L3);
              right_done_d = (state_q == R3);
            end else begin
              err = 1'b1;
            end
          end
          default: begin
            err = 1'b1;
          end
        endcase
      end

      // An erroring sample always lands in IDLE; it never starts a new sequence.
      if (err) begin
        state_d      = IDLE;
        hold_cnt_d   = '0;
        seq_err_d    = 1'b1;
        left_done_d  = 1'b0;
        right_done_d = 1'b0;
        if (err_cnt_q != '1) begin
          err_cnt_d = err_cnt_q + ERR_CW'(1);
        end
      end
    end

    mode_d  = mode_of(state_d);
    phase_d = phase_of(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_cnt_q   <= '0;
      mode_q       <= 2'b00;
      phase_q      <= 2'd0;
      left_done_q  <= 1'b0;
      right_done_q <= 1'b0;
      seq_err_q    <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      mode_q       <= mode_d;
      phase_q      <= phase_d;
      left_done_q  <= left_done_d;
      right_done_q <= right_done_d;
      seq_err_q    <= seq_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign mode       = mode_q;
  assign phase      = phase_q;
  assign left_done  = left_done_q;
  assign right_done = right_done_q;
  assign seq_err    = seq_err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_turn_signal_decoder.sv
// tb/tb_turn_signal_decoder.sv - directed vector bench for turn_signal_decoder
// Main DUT uses defaults; a second instance with ERR_CW=2 covers counter saturation.

module tb_turn_signal_decoder;

  logic       clk;
  logic       rst_n;
  logic       clk_en;
  logic [5:0] leds;

  logic [1:0] mode, mode2;
  logic [1:0] phase, phase2;
  logic       left_done, left_done2;
  logic       right_done, right_done2;
  logic       seq_err, seq_err2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;

  int checks = 0;
  int passed = 0;

  turn_signal_decoder #(.MAX_HOLD(4), .ERR_CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .leds(leds),
    .mode(mode), .phase(phase), .left_done(left_done), .right_done(right_done),
    .seq_err(seq_err), .err_cnt(err_cnt)
  );

  turn_signal_decoder #(.MAX_HOLD(4), .ERR_CW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .leds(leds),
    .mode(mode2), .phase(phase2), .left_done(left_done2), .right_done(right_done2),
    .seq_err(seq_err2), .err_cnt(err_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] leds;
    logic [1:0] mode;
    logic [1:0] phase;
    logic       ld;
    logic       rd;
    logic       err;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  function automatic logic [14:0] pack_out();
    return {mode, phase, left_done, right_done, seq_err, err_cnt};
  endfunction

  // One sample strike; outputs are then observed at the following falling edge.
  task automatic tick(input logic [5:0] v);
    @(negedge clk);
    leds   = v;
    clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
  endtask

  task automatic add(input logic [5:0] l, input logic [1:0] m, input logic [1:0] p,
                     input logic ld, input logic rd, input logic e, input logic [7:0] c);
    vec_t v;
    v.leds = l; v.mode = m; v.phase = p; v.ld = ld; v.rd = rd; v.err = e; v.cnt = c;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [14:0] exp;
    rst_n  = 1'b0;
    clk_en = 1'b0;
    leds   = 6'h00;

    for (int i = 0; i < 5; i++) add(6'h00, 2'b00, 2'd0, 0, 0, 0, 8'd0);
    add(6'h08, 2'b01, 2'd1, 0, 0, 0, 8'd0);
    add(6'h18, 2'b01, 2'd2, 0, 0, 0, 8'd0);
    add(6'h38, 2'b01, 2'd3, 0, 0, 0, 8'd0);
    add(6'h00, 2'b00, 2'd0, 1, 0, 0, 8'd0);
    add(6'h04, 2'b10, 2'd1, 0, 0, 0, 8'd0);
    add(6'h06, 2'b10, 2'd2, 0, 0, 0, 8'd0);
    add(6'h07, 2'b10, 2'd3, 0, 0, 0, 8'd0);
    add(6'h00, 2'b00, 2'd0, 0, 1, 0, 8'd0);
    add(6'h08, 2'b01, 2'd1, 0, 0, 0, 8'd0);
    add(6'h04, 2'b00, 2'd0, 0, 0, 1, 8'd1);
    add(6'h04, 2'b10, 2'd1, 0, 0, 0, 8'd1);
    add(6'h00, 2'b00, 2'd0, 0, 0, 0, 8'd1);
    add(6'h08, 2'b01, 2'd1, 0, 0, 0, 8'd1);
    for (int i = 0; i < 4; i++) add(6'h08, 2'b01, 2'd1, 0, 0, 0, 8'd1);
    add(6'h08, 2'b00, 2'd0, 0, 0, 1, 8'd2);
    add(6'h04, 2'b10, 2'd1, 0, 0, 0, 8'd2);
    for (int i = 0; i < 4; i++) add(6'h04, 2'b10, 2'd1, 0, 0, 0, 8'd2);
    add(6'h04, 2'b00, 2'd0, 0, 0, 1, 8'd3);
    add(6'h3F, 2'b00, 2'd0, 0, 0, 1, 8'd4);
    add(6'h08, 2'b01, 2'd1, 0, 0, 0, 8'd4);
    add(6'h18, 2'b01, 2'd2, 0, 0, 0, 8'd4);
    add(6'h18, 2'b01, 2'd2, 0, 0, 0, 8'd4);
    add(6'h00, 2'b00, 2'd0, 0, 0, 0, 8'd4);
    add(6'h04, 2'b10, 2'd1, 0, 0, 0, 8'd4);
    add(6'h07, 2'b00, 2'd0, 0, 0, 1, 8'd5);
    add(6'h0C, 2'b00, 2'd0, 0, 0, 1, 8'd6);
    add(6'h08, 2'b01, 2'd1, 0, 0, 0, 8'd6);
    add(6'h18, 2'b01, 2'd2, 0, 0, 0, 8'd6);
    add(6'h38, 2'b01, 2'd3, 0, 0, 0, 8'd6);
    add(6'h3F, 2'b00, 2'd0, 0, 0, 1, 8'd7);

    repeat (2) @(negedge clk);
    check("reset_outputs", {17'd0, pack_out()}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].leds);
      exp = {vecs[i].mode, vecs[i].phase, vecs[i].ld, vecs[i].rd, vecs[i].err, vecs[i].cnt};
      check($sformatf("vec%0d_leds%h", i, vecs[i].leds), {17'd0, pack_out()}, {17'd0, exp});
    end

    // Pulse drops on the next edge without clk_en; counter holds.
    @(negedge clk);
    check("err_pulse_clears", {23'd0, seq_err, err_cnt}, {23'd0, 1'b0, 8'd7});

    // Saturation of the 2-bit counter on repeated illegal samples.
    do_reset();
    check("sat_reset", {30'd0, err_cnt2}, 32'd0);
    tick(6'h3F); check("sat1", {30'd0, err_cnt2}, 32'd1);
    tick(6'h3F); check("sat2", {30'd0, err_cnt2}, 32'd2);
    tick(6'h3F); check("sat3", {30'd0, err_cnt2}, 32'd3);
    tick(6'h3F); check("sat4", {29'd0, seq_err2, err_cnt2}, {29'd0, 1'b1, 2'd3});
    tick(6'h3F); check("sat5", {30'd0, err_cnt2}, 32'd3);
    check("wide_cnt5", {24'd0, err_cnt}, 32'd5);

    // Asynchronous reset mid-sequence, asserted between clock edges.
    do_reset();
    tick(6'h08);
    tick(6'h18);
    check("pre_areset_L2", {28'd0, mode, phase}, {28'd0, 2'b01, 2'd2});
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("areset_immediate", {17'd0, pack_out()}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("areset_no_pulse", {17'd0, pack_out()}, 32'd0);

    // clk_en low with garbage on the bus: nothing moves.
    tick(6'h08);
    leds   = 6'h3F;
    clk_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("hold_en0_%0d", i), {17'd0, pack_out()},
            {17'd0, 2'b01, 2'd1, 3'b000, 8'd0});
    end
    tick(6'h18);
    check("resume_after_hold", {17'd0, pack_out()}, {17'd0, 2'b01, 2'd2, 3'b000, 8'd0});

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
